// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states and default timing constants for the tx and rx paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int OVERSAMPLE  = 16;
  localparam int CLK_DIV_DEF = 163;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
endpackage

// File: rtl/uart_baud_gen.sv
// baud_gen: mod-CLK_DIV divider producing a one-cycle oversample tick, synchronously clearable
module baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  // count 0..CLK_DIV-1, restarting on clear so a new frame gets full-length bits
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 UART transmitter with valid/ready input, LSB first; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_valid,
  input  logic [DBIT-1:0] tx_data,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);
  localparam int SW = $clog2(SB_TICK) > 4 ? $clog2(SB_TICK) : 4;
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  state_t state, state_n;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic tick, accept, last_os, last_sb, tx_n;
  assign accept  = tx_valid && tx_ready;
  assign last_os = tick && s == SW'(OVERSAMPLE - 1);
  assign last_sb = tick && s == SW'(SB_TICK - 1);
  baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(tick)
  );
`ifdef UART_TX_PARITY_EN
  logic par;
  // even parity of the byte as latched at acceptance
  always_ff @(posedge clk)
    par <= rst ? 1'b0 : accept ? ^tx_data : par;
`endif
  // next state, tick/bit counters, shift register and next line level
  always_comb begin
    state_n = state;
    s_n     = (state == IDLE) ? '0 : tick ? s + 1'b1 : s;
    n_n     = n;
    b_n     = b;
    case (state)
      IDLE: if (accept) begin
        state_n = START;
        b_n     = tx_data;
      end
      START: if (last_os) begin
        state_n = DATA;
        s_n     = '0;
        n_n     = '0;
      end
      DATA: if (last_os) begin
        s_n = '0;
        b_n = b >> 1;
        n_n = n + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (n == NW'(DBIT - 1)) state_n = PARITY;
`else
        if (n == NW'(DBIT - 1)) state_n = STOP;
`endif
      end
      PARITY: if (last_os) begin
        state_n = STOP;
        s_n     = '0;
      end
      STOP: if (last_sb) begin
        state_n = IDLE;
        s_n     = '0;
      end
      default: state_n = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? b_n[0] : (state_n == PARITY) ? par : 1'b1;
`else
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? b_n[0] : 1'b1;
`endif
  end
  // state register with registered outputs derived from the next state
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      b        <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      n        <= n_n;
      b        <= b_n;
      tx       <= tx_n;
      tx_ready <= state_n == IDLE;
      tx_busy  <= state_n != IDLE;
      tx_done  <= state == STOP && state_n == IDLE;
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed checks of the UART transmitter at CLK_DIV=4 (64 cycles per bit)
module tb_uart_tx_ctrl;
  localparam int CLK_DIV = 4;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NLEV = 10 + PAR;
  localparam int FL   = BIT * (1 + DBIT + PAR) + SB_TICK * CLK_DIV;
  logic clk = 0, rst = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, tx, tx_busy, tx_done;
  logic [7:0] got;
  logic gp;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uart_tx_ctrl #(.CLK_DIV(CLK_DIV), .DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input string tag);
    chk({tag, " ready"}, 32'(tx_ready), 1);
    tx_valid = 1;
    tx_data  = d;
    step();
    tx_valid = 0;
    chk({tag, " start tx/busy/ready"}, 32'({tx, tx_busy, tx_ready}), 32'b010);
  endtask
  task automatic run_frame(input logic [7:0] d, input string tag, input bit scramble,
                           output logic [7:0] g, output logic g_par);
    logic [NLEV-1:0] lev;
    int mism[NLEV];
    int rdy_bad, done_bad, lv;
    lev[0] = 1'b0;
    for (int i = 0; i < 8; i++) lev[1+i] = d[i];
    if (PAR == 1) lev[9] = ^d;
    lev[NLEV-1] = 1'b1;
    for (int i = 0; i < NLEV; i++) mism[i] = 0;
    rdy_bad  = 0;
    done_bad = 0;
    g        = 0;
    g_par    = 0;
    for (int c = 0; c < FL; c++) begin
      lv = c / BIT;
      if (tx !== lev[lv]) mism[lv]++;
      if (tx_ready !== 1'b0 || tx_busy !== 1'b1) rdy_bad++;
      if (tx_done !== 1'b0) done_bad++;
      if (c % BIT == BIT / 2 && lv >= 1 && lv <= 8) g[lv-1] = tx;
      if (c % BIT == BIT / 2 && PAR == 1 && lv == 9) g_par = tx;
      if (scramble) begin
        tx_valid = 1;
        tx_data  = 8'($urandom);
      end
      step();
    end
    if (scramble) tx_valid = 0;
    for (int i = 0; i < NLEV; i++) chk($sformatf("%s level%0d bad cycles", tag, i), 32'(mism[i]), 0);
    chk({tag, " busy during frame"}, 32'(rdy_bad), 0);
    chk({tag, " early done"}, 32'(done_bad), 0);
    chk({tag, " done/ready/tx at end"}, 32'({tx_done, tx_ready, tx}), 32'b111);
  endtask
  initial begin
    rst      = 1;
    tx_valid = 1;
    tx_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("reset cyc%0d tx/ready/busy/done", i), 32'({tx, tx_ready, tx_busy, tx_done}), 32'b1100);
    end
    rst      = 0;
    tx_valid = 0;
    step(3);
    chk("idle after reset", 32'({tx, tx_ready, tx_busy, tx_done}), 32'b1100);
    send(8'h55, "b55");
    run_frame(8'h55, "b55", 0, got, gp);
    chk("b55 decoded", 32'(got), 32'h55);
`ifdef UART_TX_PARITY_EN
    chk("b55 parity", 32'(gp), 0);
`endif
    step();
    chk("b55 done one cycle", 32'(tx_done), 0);
    step(4);
    send(8'hA3, "bA3");
    run_frame(8'hA3, "bA3", 0, got, gp);
    chk("bA3 decoded", 32'(got), 32'hA3);
    send(8'h0F, "b0F back-to-back");
    run_frame(8'h0F, "b0F", 0, got, gp);
    chk("b0F decoded", 32'(got), 32'h0F);
    step(2);
    send(8'h3C, "hold");
    run_frame(8'h3C, "hold", 1, got, gp);
    chk("hold decoded", 32'(got), 32'h3C);
    step();
    chk("hold nothing queued", 32'({tx, tx_ready, tx_busy}), 32'b110);
    step(2);
    send(8'hFF, "rstmid");
    step(4 * BIT + 20);
    chk("rstmid in data bit3", 32'({tx, tx_busy}), 32'b11);
    rst = 1;
    step();
    rst = 0;
    chk("rstmid abort tx/ready/busy/done", 32'({tx, tx_ready, tx_busy, tx_done}), 32'b1100);
    begin
      int bad = 0;
      for (int c = 0; c < FL + BIT; c++) begin
        if (tx !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1) bad++;
        step();
      end
      chk("rstmid quiet line", 32'(bad), 0);
    end
    send(8'h01, "b01");
    run_frame(8'h01, "b01", 0, got, gp);
    chk("b01 decoded", 32'(got), 32'h01);
`ifdef UART_TX_PARITY_EN
    step(3);
    send(8'h07, "p07");
    run_frame(8'h07, "p07", 0, got, gp);
    chk("p07 decoded", 32'(got), 32'h07);
    chk("p07 parity", 32'(gp), 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART 8N1 transmitter: the transmit-side counterpart to the existing UART receive path. It accepts bytes from game logic (score, status and game-over reports) over a valid/ready handshake and serializes them LSB-first onto `tx` using 16x-oversampled bit timing. It sits beside the receiver in `top` and drives the board's serial output pin, replacing the current raw `rx`-to-`tx` loopback.

## Interface

**Parameters**
- `CLK_DIV`, default 163: clock cycles per oversample tick (100 MHz / (16·38400)); legal range ≥ 2.
- `DBIT`, default 8: data bits per frame.
- `SB_TICK`, default 16: ticks per stop bit (16 gives 1 stop bit, 32 gives 2).

**Ports** (reset is `rst`, synchronous, active-high; clock is `clk`)
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `tx_valid` in 1: byte offered.
- `tx_data` in DBIT: byte to send; sampled only on acceptance.
- `tx_ready` out 1: transmitter idle and able to accept.
- `tx` out 1: serial line; idles high.
- `tx_busy` out 1: frame in progress.
- `tx_done` out 1: one-cycle pulse when a stop bit completes.

## Operation

- **Reset values** (after the `rst` edge): state IDLE, `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, shift register 0, counters 0.
- **Handshake:** a transfer occurs on any edge with `tx_valid && tx_ready`. `tx_data` is latched into the shift register. `tx_valid` without `tx_ready` is ignored; nothing is queued.
- **FSM:**
  - IDLE: `tx`=1. On acceptance, clear the baud divider and tick counter and go to START.
  - START: `tx`=0 for 16 ticks, then go to DATA with bit index 0.
  - DATA: `tx`=shreg[0] for 16 ticks, then shift right. After bit DBIT-1, go to STOP (or to PARITY when parity is enabled).
  - STOP: `tx`=1 for SB_TICK ticks, then go to IDLE.
- **Registered outputs:**
  - `tx_ready` is 1 only in IDLE.
  - `tx_busy` is the inverse of `tx_ready`.
  - `tx_done` is 1 only in the first IDLE cycle after STOP.
- **Bit order:** LSB first.
- **Tick counter:** 4 bits wide for data bits, wide enough for SB_TICK in STOP, and wraps to 0 at each bit boundary.
- **Reset mid-frame:** the frame aborts, `tx` returns to 1 on the next edge, and no `tx_done` is produced.
- **Simultaneous events:**
  - In the `tx_done` cycle `tx_ready`=1, so a new byte can be accepted the same cycle. The minimum inter-frame idle is 1 clock.
  - `rst` takes priority over acceptance.

## Timing

- **Tick:** asserted for one cycle when the divider reaches CLK_DIV-1. The divider counts 0..CLK_DIV-1 and is cleared on acceptance, so every bit is exactly 16·CLK_DIV cycles.
- **Acceptance to start bit:** `tx` falls on the edge after acceptance (latency 1).
- **Frame length** (`tx` low edge to `tx_done` edge): (16·(1+DBIT) + SB_TICK)·CLK_DIV cycles. With parity, add 16·CLK_DIV.
- **Default frame:** 8N1 with CLK_DIV=163 is 26080 cycles.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP.
  - `tx` = even parity, i.e. XOR of all DBIT bits latched at acceptance, for 16 ticks.
- `UART_TX_PARITY_EN` undefined: DATA goes directly to STOP and no parity logic is synthesized.

## Structure

- **Package `uart_pkg`:**
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - `OVERSAMPLE` = 16.
  - Default `CLK_DIV`, `DBIT` and `SB_TICK` constants, shared with the receiver.
- **Sub-module `baud_gen`:**
  - Mod-CLK_DIV counter with a synchronous `clr` input and a one-cycle `tick` output.
  - Also reusable by the receiver.

## Test plan

All scenarios use CLK_DIV=4, so 1 bit = 64 cycles.

1. **Reset:** hold `rst` 5 cycles with `tx_valid`=1 → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 throughout, and no frame starts.
2. **Send 0x55:**
   - `tx` low 1 cycle after acceptance.
   - Line sequence 0,1,0,1,0,1,0,1,0,1, each level held exactly 64 cycles.
   - `tx_done` pulses once, 640 cycles after the falling edge.
3. **Back-to-back 0xA3 then 0x0F:**
   - The second byte is accepted in the `tx_done` cycle.
   - `tx` is high for exactly 1 cycle between frames.
   - Decoded bytes are 0xA3, 0x0F.
4. **`tx_valid` held while busy, with `tx_data` changing every cycle:** only the byte present at acceptance is transmitted, and `tx_ready`=0 for the whole frame.
5. **Reset mid-frame:** assert `rst` during data bit 3 of 0xFF → `tx`=1 on the next edge, no `tx_done`, and the next byte 0x01 transmits correctly.
6. **Parity (`UART_TX_PARITY_EN`):**
   - 0x07 → parity bit 1; 0x55 → parity bit 0.
   - Frame length is 704 cycles.
